// File: rtl/prio_ctrl_pkg.sv
// rtl/prio_ctrl_pkg.sv - shared width helpers for the priority inheritance controller
package prio_ctrl_pkg;

    localparam int MAX_HOLD_DEFAULT = 255;
    localparam int HOLD_W_DEFAULT   = $clog2(MAX_HOLD_DEFAULT + 1);

    function automatic int tid_width(input int num_tasks);
        return (num_tasks > 1) ? $clog2(num_tasks) : 1;
    endfunction

    function automatic int rid_width(input int num_res);
        return (num_res > 1) ? $clog2(num_res) : 1;
    endfunction

    // A zero MAX_HOLD still needs a one-bit counter to keep the datapath legal.
    function automatic int hold_width(input int max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

endpackage

// File: rtl/priority_max_select.sv
// rtl/priority_max_select.sv - combinational arg-max over masked values, lowest index wins ties
module priority_max_select
    import prio_ctrl_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 3,
    parameter int IDX_W = tid_width(N)
) (
    input  logic [N*W-1:0]   vals_i,
    input  logic [N-1:0]     valid_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     best;

    // Strict greater-than keeps the earliest index on equal values.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        best  = '0;
        for (int i = 0; i < N; i++) begin
            if (valid_i[i] && (!found || (vals_i[i*W +: W] > best))) begin
                found = 1'b1;
                idx   = IDX_W'(i);
                best  = vals_i[i*W +: W];
            end
        end
    end

    assign found_o = found;
    assign idx_o   = idx;

endmodule

// File: rtl/priority_inheritance_ctrl.sv
// rtl/priority_inheritance_ctrl.sv - multi-resource arbiter with one-level priority inheritance
// and per-resource hold watchdogs that forcibly revoke long-held locks.
module priority_inheritance_ctrl
    import prio_ctrl_pkg::*;
#(
    parameter int NUM_TASKS  = 8,
    parameter int NUM_RES    = 2,
    parameter int PRIO_WIDTH = 3,
    parameter int MAX_HOLD   = MAX_HOLD_DEFAULT,
    parameter int TID_W      = tid_width(NUM_TASKS),
    parameter int RID_W      = rid_width(NUM_RES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_TASKS*PRIO_WIDTH-1:0] prio_def,
    input  logic [NUM_TASKS-1:0]          req,
    input  logic [NUM_TASKS-1:0]          res_need,
    input  logic [NUM_TASKS*RID_W-1:0]    res_sel,
    output logic [NUM_TASKS-1:0]          grant,
    output logic [NUM_RES-1:0]            res_locked,
    output logic [NUM_RES*TID_W-1:0]      res_owner,
    output logic [NUM_TASKS-1:0]          inherit_active,
    output logic [NUM_RES-1:0]            timeout
);

    localparam int HOLD_W = hold_width(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam bit WD_EN = (MAX_HOLD > 0);

    logic [NUM_TASKS-1:0][PRIO_WIDTH-1:0] base_q, base_d, eff;
    logic [NUM_TASKS-1:0]                 grant_q, grant_d, inherit_q, inherit_d;
    logic [NUM_TASKS-1:0]                 revoked_q, revoked_d;
    logic [NUM_RES-1:0]                   locked_q, locked_d, timeout_q, timeout_d;
    logic [NUM_RES-1:0][TID_W-1:0]        owner_q, owner_d;
    logic [NUM_RES-1:0][HOLD_W-1:0]       cnt_q, cnt_d;

    logic [NUM_TASKS-1:0][RID_W-1:0] sel;
    logic [NUM_TASKS-1:0] need, is_owner, sel_locked, holds_sel, blocked, donor, eligible;
    logic                 win_valid;
    logic [TID_W-1:0]     win_idx;

    always_comb begin
        sel        = '0;
        need       = '0;
        is_owner   = '0;
        sel_locked = '0;
        holds_sel  = '0;
        blocked    = '0;
        donor      = '0;
        for (int i = 0; i < NUM_TASKS; i++) begin
            sel[i]  = res_sel[i*RID_W +: RID_W];
            need[i] = req[i] & res_needp(i);
            for (int r = 0; r < NUM_RES; r++) begin
                if (locked_q[r] && (owner_q[r] == TID_W'(i))) is_owner[i] = 1'b1;
            end
            sel_locked[i] = need[i] & locked_q[sel[i]];
            holds_sel[i]  = sel_locked[i] & (owner_q[sel[i]] == TID_W'(i));
            // An owner asking for any other resource stalls without donating (one-level inheritance).
            blocked[i] = revoked_q[i]
                       | (sel_locked[i] & ~holds_sel[i])
                       | (need[i] & is_owner[i] & ~holds_sel[i]);
            donor[i]   = sel_locked[i] & ~holds_sel[i] & ~is_owner[i] & ~revoked_q[i];
        end
    end

    function automatic logic res_needp(input int i);
        return res_need[i] && (32'(res_sel[i*RID_W +: RID_W]) < NUM_RES);
    endfunction

    for (genvar k = 0; k < NUM_TASKS; k++) begin : g_donate
        logic [PRIO_WIDTH-1:0] eff_k;
        always_comb begin
            eff_k = base_q[k];
            for (int i = 0; i < NUM_TASKS; i++) begin
                if (donor[i] && (owner_q[sel[i]] == TID_W'(k)) && (base_q[i] > eff_k)) begin
                    eff_k = base_q[i];
                end
            end
        end
        assign eff[k] = eff_k;
    end

    assign eligible = req & ~blocked;

    priority_max_select #(
        .N     (NUM_TASKS),
        .W     (PRIO_WIDTH),
        .IDX_W (TID_W)
    ) u_arb (
        .vals_i  (eff),
        .valid_i (eligible),
        .found_o (win_valid),
        .idx_o   (win_idx)
    );

    always_comb begin
        base_d    = start ? prio_def : base_q;
        grant_d   = '0;
        inherit_d = '0;
        locked_d  = locked_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        timeout_d = '0;
        revoked_d = revoked_q & req;
        if (win_valid) begin
            grant_d[win_idx]   = 1'b1;
            inherit_d[win_idx] = eff[win_idx] > base_q[win_idx];
        end
        // Release takes precedence over watchdog expiry on the same cycle.
        for (int r = 0; r < NUM_RES; r++) begin
            if (locked_q[r]) begin
                if (!req[owner_q[r]]) begin
                    locked_d[r] = 1'b0;
                end else if (WD_EN && (cnt_q[r] == HOLD_LAST)) begin
                    locked_d[r]            = 1'b0;
                    timeout_d[r]           = 1'b1;
                    revoked_d[owner_q[r]]  = 1'b1;
                end
                if (cnt_q[r] != HOLD_SAT) cnt_d[r] = cnt_q[r] + 1'b1;
            end
        end
        if (win_valid && need[win_idx] && !locked_q[sel[win_idx]]) begin
            locked_d[sel[win_idx]] = 1'b1;
            owner_d[sel[win_idx]]  = win_idx;
            cnt_d[sel[win_idx]]    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q    <= '0;
            grant_q   <= '0;
            inherit_q <= '0;
            revoked_q <= '0;
            locked_q  <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= '0;
        end else begin
            base_q    <= base_d;
            grant_q   <= grant_d;
            inherit_q <= inherit_d;
            revoked_q <= revoked_d;
            locked_q  <= locked_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant          = grant_q;
    assign res_locked     = locked_q;
    assign res_owner      = owner_q;
    assign inherit_active = inherit_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_priority_inheritance_ctrl.sv
// tb/tb_priority_inheritance_ctrl.sv - directed self-checking bench for priority_inheritance_ctrl
module tb_priority_inheritance_ctrl;

    localparam int NT = 8;
    localparam int NR = 2;
    localparam int PW = 3;
    localparam int TW = 3;
    localparam int RW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [NT*PW-1:0] prio_def = '0;
    logic [NT-1:0]    req = '0;
    logic [NT-1:0]    res_need = '0;
    logic [NT*RW-1:0] res_sel = '0;

    logic [NT-1:0]    grant, inherit_active, w_grant, w_inherit;
    logic [NR-1:0]    res_locked, timeout, w_locked, w_timeout;
    logic [NR*TW-1:0] res_owner, w_owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    priority_inheritance_ctrl #(.NUM_TASKS(NT), .NUM_RES(NR), .PRIO_WIDTH(PW), .MAX_HOLD(255)) u_dut (
        .clk(clk), .rst(rst), .start(start), .prio_def(prio_def), .req(req),
        .res_need(res_need), .res_sel(res_sel), .grant(grant), .res_locked(res_locked),
        .res_owner(res_owner), .inherit_active(inherit_active), .timeout(timeout)
    );

    priority_inheritance_ctrl #(.NUM_TASKS(NT), .NUM_RES(NR), .PRIO_WIDTH(PW), .MAX_HOLD(4)) u_wd (
        .clk(clk), .rst(rst), .start(start), .prio_def(prio_def), .req(req),
        .res_need(res_need), .res_sel(res_sel), .grant(w_grant), .res_locked(w_locked),
        .res_owner(w_owner), .inherit_active(w_inherit), .timeout(w_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prio(input logic [PW-1:0] p0, p1, p2, p3);
        prio_def = '0;
        prio_def[0*PW +: PW] = p0;
        prio_def[1*PW +: PW] = p1;
        prio_def[2*PW +: PW] = p2;
        prio_def[3*PW +: PW] = p3;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got %b want 0", grant); end
        checks++; if (res_locked !== '0) begin errors++; $display("FAIL reset_locked got %b want 0", res_locked); end
        checks++; if (res_owner !== '0) begin errors++; $display("FAIL reset_owner got %b want 0", res_owner); end
        checks++; if (inherit_active !== '0) begin errors++; $display("FAIL reset_inherit got %b want 0", inherit_active); end
        checks++; if (timeout !== '0 || w_timeout !== '0) begin errors++; $display("FAIL reset_timeout got %b/%b want 0", timeout, w_timeout); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        load_prio(3'd1, 3'd5, 3'd3, 3'd5);
        req = 8'b0000_0111;
        checks++; if (grant !== 8'b0) begin errors++; $display("FAIL basic_latency got %b want 0", grant); end
        step();
        checks++; if (grant !== 8'b0000_0010) begin errors++; $display("FAIL basic_grant got %b want 00000010", grant); end
        checks++; if (inherit_active !== 8'b0) begin errors++; $display("FAIL basic_inherit got %b want 0", inherit_active); end
        req = 8'b0000_1010;
        step();
        checks++; if (grant !== 8'b0000_0010) begin errors++; $display("FAIL tie_low_index got %b want 00000010", grant); end
        req = 8'b0000_1000;
        step();
        checks++; if (grant !== 8'b0000_1000) begin errors++; $display("FAIL single_req got %b want 00001000", grant); end
        // New priorities load at the edge; this cycle's arbitration still sees the old ones.
        prio_def = '0;
        prio_def[0 +: PW] = 3'd7;
        start = 1'b1;
        req = 8'b0000_0011;
        step();
        start = 1'b0;
        checks++; if (grant !== 8'b0000_0010) begin errors++; $display("FAIL start_old_prio got %b want 00000010", grant); end
        step();
        checks++; if (grant !== 8'b0000_0001) begin errors++; $display("FAIL start_new_prio got %b want 00000001", grant); end
        req = '0;
        step();
        checks++; if (grant !== 8'b0) begin errors++; $display("FAIL idle_grant got %b want 0", grant); end
    endtask

    task automatic test_inherit_handover();
        load_prio(3'd1, 3'd4, 3'd6, 3'd2);
        req = 8'b0000_0001; res_need = 8'b0000_0001; res_sel = '0;
        step();
        checks++; if (grant !== 8'b0000_0001 || res_locked !== 2'b01) begin errors++; $display("FAIL acquire got grant %b locked %b want 00000001 01", grant, res_locked); end
        checks++; if (res_owner[2:0] !== 3'd0) begin errors++; $display("FAIL acquire_owner got %0d want 0", res_owner[2:0]); end
        req = 8'b0000_0111; res_need = 8'b0000_0101;
        step();
        checks++; if (grant !== 8'b0000_0001) begin errors++; $display("FAIL inherit_grant got %b want 00000001", grant); end
        checks++; if (inherit_active !== 8'b0000_0001) begin errors++; $display("FAIL inherit_active got %b want 00000001", inherit_active); end
        req = 8'b0000_0110;
        step();
        checks++; if (res_locked !== 2'b00) begin errors++; $display("FAIL release_locked got %b want 00", res_locked); end
        checks++; if (grant !== 8'b0000_0010 || inherit_active !== 8'b0) begin errors++; $display("FAIL release_grant got %b/%b want 00000010/0", grant, inherit_active); end
        step();
        checks++; if (grant !== 8'b0000_0100 || res_locked !== 2'b01) begin errors++; $display("FAIL handover got grant %b locked %b want 00000100 01", grant, res_locked); end
        checks++; if (res_owner[2:0] !== 3'd2) begin errors++; $display("FAIL handover_owner got %0d want 2", res_owner[2:0]); end
        req = '0; res_need = '0;
        step();
        checks++; if (res_locked !== 2'b00 || grant !== 8'b0) begin errors++; $display("FAIL final_release got locked %b grant %b want 00 0", res_locked, grant); end
    endtask

    task automatic test_multi_resource();
        load_prio(3'd1, 3'd2, 3'd6, 3'd4);
        req = 8'b0000_0001; res_need = 8'b0000_0001; res_sel = '0;
        step();
        req = 8'b0000_0011; res_need = 8'b0000_0011; res_sel = 8'b0000_0010;
        step();
        checks++; if (grant !== 8'b0000_0010 || res_locked !== 2'b11) begin errors++; $display("FAIL multi_acquire got grant %b locked %b want 00000010 11", grant, res_locked); end
        checks++; if (res_owner !== 6'b001_000) begin errors++; $display("FAIL multi_owner got %b want 001000", res_owner); end
        req = 8'b0000_1111; res_need = 8'b0000_1111; res_sel = 8'b0000_1010;
        step();
        checks++; if (grant !== 8'b0000_0001 || inherit_active !== 8'b0000_0001) begin errors++; $display("FAIL multi_boost0 got grant %b inh %b want 00000001 00000001", grant, inherit_active); end
        req = 8'b0000_1011;
        step();
        checks++; if (grant !== 8'b0000_0010 || inherit_active !== 8'b0000_0010) begin errors++; $display("FAIL multi_boost1 got grant %b inh %b want 00000010 00000010", grant, inherit_active); end
    endtask

    task automatic test_async_reset();
        checks++; if (res_locked !== 2'b11) begin errors++; $display("FAIL pre_reset_locked got %b want 11", res_locked); end
        #2 rst = 1'b0;
        #1;
        checks++; if (grant !== '0 || inherit_active !== '0) begin errors++; $display("FAIL async_grant got %b/%b want 0/0", grant, inherit_active); end
        checks++; if (res_locked !== '0 || res_owner !== '0) begin errors++; $display("FAIL async_locks got %b/%b want 0/0", res_locked, res_owner); end
        checks++; if (timeout !== '0 || w_timeout !== '0) begin errors++; $display("FAIL async_timeout got %b/%b want 0/0", timeout, w_timeout); end
        req = '0; res_need = '0; res_sel = '0;
        step();
        rst = 1'b1;
        step();
        checks++; if (res_locked !== '0 || grant !== '0) begin errors++; $display("FAIL post_reset got locked %b grant %b want 0 0", res_locked, grant); end
    endtask

    task automatic test_watchdog();
        load_prio(3'd0, 3'd0, 3'd0, 3'd3);
        req = 8'b0000_1000; res_need = 8'b0000_1000; res_sel = 8'b0000_1000;
        step();
        checks++; if (w_locked !== 2'b10 || w_owner[5:3] !== 3'd3) begin errors++; $display("FAIL wd_acquire got locked %b owner %0d want 10 3", w_locked, w_owner[5:3]); end
        for (int c = 2; c <= 4; c++) begin
            step();
            checks++; if (w_locked !== 2'b10 || w_timeout !== 2'b00) begin errors++; $display("FAIL wd_hold_cycle%0d got locked %b to %b want 10 00", c, w_locked, w_timeout); end
        end
        step();
        checks++; if (w_timeout !== 2'b10 || w_locked !== 2'b00) begin errors++; $display("FAIL wd_expire got to %b locked %b want 10 00", w_timeout, w_locked); end
        checks++; if (res_locked !== 2'b10 || timeout !== 2'b00) begin errors++; $display("FAIL wd_long_hold got locked %b to %b want 10 00", res_locked, timeout); end
        step();
        checks++; if (w_timeout !== 2'b00 || w_grant !== 8'b0 || w_locked !== 2'b00) begin errors++; $display("FAIL wd_revoked got to %b grant %b locked %b want 00 0 00", w_timeout, w_grant, w_locked); end
        req = '0;
        step();
        req = 8'b0000_1000;
        step();
        checks++; if (w_grant !== 8'b0000_1000 || w_locked !== 2'b10) begin errors++; $display("FAIL wd_reacquire got grant %b locked %b want 00001000 10", w_grant, w_locked); end
        repeat (3) step();
        req = '0;
        step();
        checks++; if (w_timeout !== 2'b00 || w_locked !== 2'b00) begin errors++; $display("FAIL wd_release_wins got to %b locked %b want 00 00", w_timeout, w_locked); end
        req = 8'b0000_1000;
        step();
        checks++; if (w_grant !== 8'b0000_1000) begin errors++; $display("FAIL wd_not_revoked got %b want 00001000", w_grant); end
        req = '0; res_need = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inherit_handover();
        test_multi_resource();
        test_async_reset();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit reached want finish earlier");
        $fatal(1);
    end

endmodule
